tilt_axis_compare: RTL and testbench

// - Parametrised successor of the single-axis accelerometer comparator, sitting between the MPU6050 register reader and the LED/sign outputs.
// - Takes N_AXES signed samples per completed read and saturates each to a magnitude.
// - Applies a per-axis activity threshold with hysteresis; picks the dominant axis over a sequential argmax and debounces it.
// - Drives active-low per-axis LEDs and sign bits, then pulses RESCAN to restart the reader.

---
 rtl/tilt_cmp_pkg.sv | 8 +
 rtl/tilt_mag_sat.sv | 11 +
 rtl/tilt_axis_compare.sv | 109 ++++++++++
 tb/tb_tilt_axis_compare.sv | 118 +++++++++++
 4 files changed

// File: rtl/tilt_cmp_pkg.sv
// tilt_cmp_pkg: shared FSM encoding and index-width helper for the tilt comparator.
package tilt_cmp_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, UPDATE, DONE} state_t;
  // Candidates are idx_w(N)+1 bits wide; a set MSB encodes "no active axis".
  function automatic int idx_w(input int n);
    return n <= 1 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tilt_mag_sat.sv
// tilt_mag_sat: saturating absolute value of a signed sample (most-negative maps to max positive).
module tilt_mag_sat #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] mag
);
  always_comb begin
    mag = !x[WIDTH-1] ? x : x == {1'b1, {(WIDTH-1){1'b0}}} ? {1'b0, {(WIDTH-1){1'b1}}} : -x;
  end
endmodule

// File: rtl/tilt_axis_compare.sv
// tilt_axis_compare: per-axis hysteresis threshold, debounced dominant-axis argmax; IRQ output with TILT_CMP_IRQ_EN.
module tilt_axis_compare
  import tilt_cmp_pkg::*;
#(
  parameter int N_AXES     = 3,
  parameter int WIDTH      = 8,
  parameter int THRESH     = 16,
  parameter int HYST       = 4,
  parameter int STABLE_CNT = 2,
  localparam int IW        = idx_w(N_AXES)
) (
  input  logic                    MCLK,
  input  logic                    RST,
  input  logic                    TIC,
  input  logic                    COMPLETED,
  input  logic [N_AXES*WIDTH-1:0] AXIS_DATA,
  output logic                    RESCAN,
  output logic [N_AXES-1:0]       LED,
  output logic [N_AXES-1:0]       SIGN,
  output logic [IW-1:0]           DOM_AXIS,
  output logic                    DOM_VALID
`ifdef TILT_CMP_IRQ_EN
  ,output logic                   IRQ
`endif
);
  localparam int CW = idx_w(STABLE_CNT + 1);
  localparam logic [IW:0] NONE = {1'b1, {IW{1'b0}}};
  localparam logic [WIDTH-1:0] TH = WIDTH'(THRESH);
  localparam logic [WIDTH-1:0] LO = WIDTH'(THRESH - HYST);
  localparam logic [CW-1:0] SC = CW'(STABLE_CNT);
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [IW:0] best, cand;
  logic [WIDTH-1:0] bestmag, cur, mag;
  logic [N_AXES*WIDTH-1:0] samp;
  logic [N_AXES-1:0] active;
  logic [CW-1:0] cnt, cnt_nxt;
  logic act_nxt, take, last, settle, dom_v_nxt;
  logic [IW-1:0] dom_a_nxt;
`ifdef TILT_CMP_IRQ_EN
  logic chg;
`endif
  assign cur = samp[idx*WIDTH +: WIDTH];
  tilt_mag_sat #(.WIDTH(WIDTH)) u_mag (.x(cur), .mag(mag));
  always_comb begin
    last = idx == IW'(N_AXES - 1);
    nxt = state == IDLE ? (TIC && COMPLETED ? SCAN : IDLE) :
          state == SCAN ? (last ? UPDATE : SCAN) :
          state == UPDATE ? DONE : IDLE;
    RESCAN = state == DONE;
`ifdef TILT_CMP_IRQ_EN
    IRQ = state == DONE && chg;
`endif
    // A zero magnitude never counts as active, even when THRESH-HYST is 0.
    act_nxt = mag != '0 && (active[idx] ? mag >= LO : mag > TH);
    take = act_nxt && mag > bestmag;
    cnt_nxt = best == cand ? (cnt == SC ? cnt : cnt + 1'b1) : CW'(1);
    settle = cnt_nxt == SC;
    dom_a_nxt = settle ? best[IW-1:0] : DOM_AXIS;
    dom_v_nxt = settle ? !best[IW] : DOM_VALID;
  end
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state <= IDLE;
      idx <= '0;
      best <= NONE;
      bestmag <= '0;
      samp <= '0;
      active <= '0;
      cand <= '0;
      cnt <= '0;
      LED <= '1;
      SIGN <= '1;
      DOM_AXIS <= '0;
      DOM_VALID <= 1'b0;
`ifdef TILT_CMP_IRQ_EN
      chg <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && TIC && COMPLETED) begin
        samp <= AXIS_DATA;
        idx <= '0;
        best <= NONE;
        bestmag <= '0;
      end
      if (state == SCAN) begin
        active[idx] <= act_nxt;
        idx <= idx + 1'b1;
        if (take) begin
          best <= {1'b0, idx};
          bestmag <= mag;
        end
      end
      if (state == UPDATE) begin
        cand <= best;
        cnt <= cnt_nxt;
        DOM_AXIS <= dom_a_nxt;
        DOM_VALID <= dom_v_nxt;
        LED <= ~active;
        for (int i = 0; i < N_AXES; i++)
          if (active[i]) SIGN[i] <= ~samp[i*WIDTH + WIDTH - 1];
`ifdef TILT_CMP_IRQ_EN
        chg <= dom_a_nxt != DOM_AXIS || dom_v_nxt != DOM_VALID;
`endif
      end
    end
  end
endmodule

// File: tb/tb_tilt_axis_compare.sv
// tb_tilt_axis_compare: scoreboard bench; expected results queued per accepted set, checked on each RESCAN.
module tb_tilt_axis_compare;
  logic MCLK = 1'b0, RST = 1'b1, TIC = 1'b0, COMPLETED = 1'b0;
  logic [23:0] AXIS_DATA = '0;
  logic RESCAN, DOM_VALID;
  logic [2:0] LED, SIGN;
  logic [1:0] DOM_AXIS;
`ifdef TILT_CMP_IRQ_EN
  logic IRQ;
`endif
  typedef struct {
    logic [2:0] led, sign;
    logic [1:0] dom;
    logic dv, irq;
    int acc;
  } exp_t;
  exp_t q[$];
  int checks = 0, errs = 0, cyc = 0, rescans = 0, sent = 0, r0;
  tilt_axis_compare #(.N_AXES(3), .WIDTH(8), .THRESH(16), .HYST(4), .STABLE_CNT(2)) dut (
    .MCLK(MCLK), .RST(RST), .TIC(TIC), .COMPLETED(COMPLETED), .AXIS_DATA(AXIS_DATA),
    .RESCAN(RESCAN), .LED(LED), .SIGN(SIGN), .DOM_AXIS(DOM_AXIS), .DOM_VALID(DOM_VALID)
`ifdef TILT_CMP_IRQ_EN
    , .IRQ(IRQ)
`endif
  );
  always #5 MCLK = ~MCLK;
  always @(posedge MCLK) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge MCLK) begin
    exp_t e;
    if (RESCAN === 1'b1) begin
      rescans++;
      if (q.size() == 0) chk("unexpected_rescan", 1, 0);
      else begin
        e = q.pop_front();
        chk("latency_edges", cyc - e.acc + 1, 5);
        chk("led", LED, e.led);
        chk("sign", SIGN, e.sign);
        chk("dom_axis", DOM_AXIS, e.dom);
        chk("dom_valid", DOM_VALID, e.dv);
`ifdef TILT_CMP_IRQ_EN
        chk("irq", IRQ, e.irq);
`endif
      end
    end
  end
  task automatic send(input logic [7:0] x, y, z, input logic [2:0] led, sign,
                      input logic [1:0] dom, input logic dv, irq);
    exp_t e;
    @(negedge MCLK);
    TIC = 1'b1; COMPLETED = 1'b1; AXIS_DATA = {z, y, x};
    @(posedge MCLK);
    #1;
    e.led = led; e.sign = sign; e.dom = dom; e.dv = dv; e.irq = irq; e.acc = cyc;
    q.push_back(e);
    sent++;
    TIC = 1'b0; COMPLETED = 1'b0; AXIS_DATA = 24'($urandom);
    repeat (6) @(posedge MCLK);
  endtask
  task automatic chk_reset_state();
    chk("rst_led", LED, 3'b111);
    chk("rst_sign", SIGN, 3'b111);
    chk("rst_rescan", RESCAN, 0);
    chk("rst_dom_axis", DOM_AXIS, 0);
    chk("rst_dom_valid", DOM_VALID, 0);
  endtask
  initial begin
    repeat (2) @(posedge MCLK);
    @(negedge MCLK);
    chk_reset_state();
    RST = 1'b0;
    r0 = rescans;
    TIC = 1'b1; COMPLETED = 1'b0;
    repeat (10) @(posedge MCLK);
    @(negedge MCLK);
    TIC = 1'b0;
    chk("no_rescan_without_completed", rescans - r0, 0);
    send(8'hD8, 8'd10, 8'd20, 3'b010, 3'b110, 2'd0, 1'b0, 1'b0);
    send(8'hD8, 8'd10, 8'd20, 3'b010, 3'b110, 2'd0, 1'b1, 1'b1);
    send(8'd17, 8'd0, 8'd0, 3'b110, 3'b111, 2'd0, 1'b1, 1'b0);
    send(8'd13, 8'd0, 8'd0, 3'b110, 3'b111, 2'd0, 1'b1, 1'b0);
    send(8'd11, 8'd0, 8'd0, 3'b111, 3'b111, 2'd0, 1'b1, 1'b0);
    send(8'h80, 8'd127, 8'd0, 3'b100, 3'b110, 2'd0, 1'b1, 1'b0);
    send(8'h80, 8'd127, 8'd0, 3'b100, 3'b110, 2'd0, 1'b1, 1'b0);
    send(8'd0, 8'd50, 8'd0, 3'b101, 3'b110, 2'd0, 1'b1, 1'b0);
    send(8'd0, 8'd50, 8'd0, 3'b101, 3'b110, 2'd1, 1'b1, 1'b1);
    send(8'd50, 8'd0, 8'd0, 3'b110, 3'b111, 2'd1, 1'b1, 1'b0);
    send(8'd0, 8'd50, 8'd0, 3'b101, 3'b111, 2'd1, 1'b1, 1'b0);
    send(8'd50, 8'd0, 8'd0, 3'b110, 3'b111, 2'd1, 1'b1, 1'b0);
    send(8'd50, 8'd0, 8'd0, 3'b110, 3'b111, 2'd0, 1'b1, 1'b1);
    @(negedge MCLK);
    TIC = 1'b1; COMPLETED = 1'b1; AXIS_DATA = {8'd20, 8'd10, 8'hD8};
    @(posedge MCLK);
    #1;
    TIC = 1'b0; COMPLETED = 1'b0;
    r0 = rescans;
    @(negedge MCLK);
    RST = 1'b1;
    @(posedge MCLK);
    @(negedge MCLK);
    chk_reset_state();
    RST = 1'b0;
    repeat (8) @(posedge MCLK);
    chk("no_rescan_after_abort", rescans - r0, 0);
    send(8'hD8, 8'd10, 8'd20, 3'b010, 3'b110, 2'd0, 1'b0, 1'b0);
    repeat (3) @(posedge MCLK);
    chk("queue_drained", q.size(), 0);
    chk("rescan_total", rescans, sent);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule
